fifo_wr_sched: RTL and testbench
================================

// Module: fifo_wr_sched
// PURPOSE
//  Two-requester write scheduler in front of the Xillybus-facing FIFO write port.
//  Grants one source at a time in bursts of up to BURST beats, round-robin between sources.
//  Throttles new bursts while prog_full is high; stalls beats while fifo_full is high.
//  Counts accepted beats per source for debug readout.
// PARAMETERS
//  DW     32  data width of both sources and fifo_din
//  BURST  16  max beats per grant (>=1); beat counter width = $clog2(BURST+1)
// PORTS
//  prg_clk      in   1   single clock; all logic on posedge
//  prg_rst_n    in   1   asynchronous, active-low reset
//  s0_valid     in   1   source 0 has a beat
//  s0_data      in   DW  source 0 beat
//  s0_ready     out  1   source 0 beat accepted this cycle when valid&ready
//  s1_valid     in   1   source 1 has a beat
//  s1_data      in   DW  source 1 beat
//  s1_ready     out  1   source 1 beat accepted this cycle when valid&ready
//  prog_full    in   1   FIFO threshold flag; blocks new bursts
//  fifo_full    in   1   FIFO hard full; blocks individual beats
//  fifo_wr_en   out  1   FIFO write strobe
//  fifo_din     out  DW  FIFO write data
//  grant        out  2   one-hot owner (bit0=s0, bit1=s1); 2'b00 when no owner
//  busy         out  1   1 while state != IDLE
//  beats0       out  32  accepted beats from s0, wraps 2^32-1 -> 0
//  beats1       out  32  accepted beats from s1, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, grant=0, rr_ptr=0 (s0 first),
//   beat_cnt=0, beats0=beats1=0; s*_ready=0, fifo_wr_en=0, fifo_din=0, busy=0.
//  States: IDLE, BURST, THROTTLE.
//  IDLE: if prog_full -> THROTTLE. Else if any valid: pick per rr_ptr
//   (rr_ptr=0 prefers s0, =1 prefers s1; the other wins if the preferred is idle),
//   load grant, beat_cnt=0 -> BURST next cycle. No beat is transferred in IDLE.
//  THROTTLE: grant=0; return to IDLE on the first cycle prog_full is sampled low.
//  BURST: ready of granted source = !fifo_full; other source ready=0.
//   fifo_wr_en = granted valid & !fifo_full (combinational, zero latency);
//   fifo_din = granted data (mux by grant, 0 when grant=0).
//   On each transfer: beat_cnt++, owner beats counter ++.
//   Burst ends (-> IDLE, grant=0, rr_ptr = index of the other source) when:
//    (a) transfer with beat_cnt==BURST-1, or
//    (b) granted valid low for a cycle (source released; no transfer that cycle).
//   prog_full rising mid-burst does NOT end the burst; it only blocks the next grant.
//   fifo_full high: hold state, beat_cnt, grant; no write; source must hold data.
//  Simultaneous: fifo_full & burst-end condition (a) -> no transfer, stay in BURST.
//  Min idle gap: 1 cycle (IDLE) between consecutive bursts, even to the same source.
//  Only one of s0_ready/s1_ready is high in any cycle; never high outside BURST.
//  Reset mid-burst: the in-flight beat is not written; counters clear.
// TESTING
//  1 s0 valid continuously, s1 idle, BURST=16 -> 16 writes, 1 idle cycle, 16 more; beats0=32.
//  2 both valid continuously -> grants alternate s0,s1,s0 in 16-beat bursts; fifo_din tracks owner.
//  3 fifo_full high for 5 cycles at beat 7 -> no wr_en for those 5; burst still totals 16 beats.
//  4 prog_full rises at beat 3 -> burst completes 16 beats, THROTTLE until prog_full low,
//    then next grant to the other source.
//  5 s1 drops valid after 4 beats -> burst ends, rr_ptr=0, beats1 incremented by exactly 4.
//  6 prg_rst_n low mid-burst for 1 cycle -> all outputs 0 immediately; restart grants s0 first.

Source files
------------

// File: rtl/fifo_wr_sched.sv
// Two-source round-robin burst scheduler that feeds a FIFO write port.
// Bursts are throttled by prog_full, and each beat is stalled by fifo_full.
module fifo_wr_sched #(
  parameter int DW    = 32,
  parameter int BURST = 16
) (
  input  logic          prg_clk,
  input  logic          prg_rst_n,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  input  logic          prog_full,
  input  logic          fifo_full,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [31:0]   beats0,
  output logic [31:0]   beats1
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_THROTTLE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]   beats0_q, beats0_d;
  logic [31:0]   beats1_q, beats1_d;

  logic          in_burst;
  logic          gvalid;
  logic          xfer;
  logic          pick_s1;

  always_ff @(posedge prg_clk or negedge prg_rst_n) begin
    if (!prg_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
      beats0_q   <= '0;
      beats1_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      beats0_q   <= beats0_d;
      beats1_q   <= beats1_d;
    end
  end

  // Handshake outputs are combinational so that a beat moves in the same cycle it is offered.
  always_comb begin
    in_burst   = (state_q == ST_BURST);
    gvalid     = (grant_q[0] & s0_valid) | (grant_q[1] & s1_valid);
    xfer       = in_burst & gvalid & ~fifo_full;
    s0_ready   = in_burst & grant_q[0] & ~fifo_full;
    s1_ready   = in_burst & grant_q[1] & ~fifo_full;
    fifo_wr_en = xfer;
    if (grant_q[0])      fifo_din = s0_data;
    else if (grant_q[1]) fifo_din = s1_data;
    else                 fifo_din = '0;
    grant      = grant_q;
    busy       = (state_q != ST_IDLE);
    beats0     = beats0_q;
    beats1     = beats1_q;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    beats0_d   = beats0_q;
    beats1_d   = beats1_q;
    pick_s1    = rr_ptr_q ? s1_valid : ~s0_valid;

    case (state_q)
      ST_IDLE: begin
        if (prog_full) begin
          state_d = ST_THROTTLE;
          grant_d = '0;
        end else if (s0_valid | s1_valid) begin
          state_d    = ST_BURST;
          grant_d    = pick_s1 ? 2'b10 : 2'b01;
          beat_cnt_d = '0;
        end
      end

      ST_THROTTLE: begin
        grant_d = '0;
        if (!prog_full) state_d = ST_IDLE;
      end

      ST_BURST: begin
        // A released source ends the burst even while the FIFO is full.
        if (!gvalid) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          rr_ptr_d   = grant_q[0];
          beat_cnt_d = '0;
        end else if (!fifo_full) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (grant_q[0]) beats0_d = beats0_q + 32'd1;
          if (grant_q[1]) beats1_d = beats1_q + 32'd1;
          if (beat_cnt_q == LAST) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            rr_ptr_d   = grant_q[0];
            beat_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed plus randomized bench for fifo_wr_sched against a transaction-level reference model.
module tb_fifo_wr_sched;

  localparam int DW    = 32;
  localparam int BURST = 16;

  logic          clk;
  logic          rst_n;
  logic          s0_valid, s1_valid;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready;
  logic          prog_full, fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic [1:0]    grant;
  logic          busy;
  logic [31:0]   beats0, beats1;

  fifo_wr_sched #(.DW(DW), .BURST(BURST)) dut (
    .prg_clk    (clk),
    .prg_rst_n  (rst_n),
    .s0_valid   (s0_valid),
    .s0_data    (s0_data),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_data    (s1_data),
    .s1_ready   (s1_ready),
    .prog_full  (prog_full),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .busy       (busy),
    .beats0     (beats0),
    .beats1     (beats1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port, how many beats it has moved, and who goes next.
  int          m_owner;
  bit          m_throttle;
  int          m_moved;
  int          m_next;
  logic [31:0] m_b0, m_b1;

  int       wr_seen;
  logic [1:0] prev_grant;
  int       grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_throttle = 1'b0;
    m_moved    = 0;
    m_next     = 0;
    m_b0       = '0;
    m_b1       = '0;
    prev_grant = 2'b00;
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic step();
    logic          gv;
    logic [DW-1:0] edin;
    logic [1:0]    egnt;
    #2;
    gv   = (m_owner == 0) ? s0_valid : (m_owner == 1) ? s1_valid : 1'b0;
    edin = (m_owner == 0) ? s0_data  : (m_owner == 1) ? s1_data  : '0;
    egnt = (m_owner == 0) ? 2'b01    : (m_owner == 1) ? 2'b10    : 2'b00;
    chk("grant",    64'(grant),      64'(egnt));
    chk("s0_ready", 64'(s0_ready),   64'((m_owner == 0) && !fifo_full));
    chk("s1_ready", 64'(s1_ready),   64'((m_owner == 1) && !fifo_full));
    chk("wr_en",    64'(fifo_wr_en), 64'((m_owner >= 0) && gv && !fifo_full));
    chk("din",      64'(fifo_din),   64'(edin));
    chk("busy",     64'(busy),       64'((m_owner >= 0) || m_throttle));
    chk("beats0",   64'(beats0),     64'(m_b0));
    chk("beats1",   64'(beats1),     64'(m_b1));
    if (fifo_wr_en) wr_seen++;
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(int'(grant));
    prev_grant = grant;
    @(posedge clk);
    if (m_throttle) begin
      if (!prog_full) m_throttle = 1'b0;
    end else if (m_owner < 0) begin
      if (prog_full) m_throttle = 1'b1;
      else if (s0_valid || s1_valid) begin
        if (m_next == 0) m_owner = s0_valid ? 0 : 1;
        else             m_owner = s1_valid ? 1 : 0;
        m_moved = 0;
      end
    end else if (!gv) begin
      m_next  = 1 - m_owner;
      m_owner = -1;
    end else if (!fifo_full) begin
      if (m_owner == 0) m_b0 = m_b0 + 32'd1;
      else              m_b1 = m_b1 + 32'd1;
      m_moved++;
      if (m_moved == BURST) begin
        m_next  = 1 - m_owner;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      s0_data = $urandom;
      s1_data = $urandom;
      step();
    end
  endtask

  // Pulses reset for one cycle starting at a negedge; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_grant",  64'(grant),      64'(0));
    chk("rst_rdy",    64'({s0_ready, s1_ready}), 64'(0));
    chk("rst_wr_en",  64'(fifo_wr_en), 64'(0));
    chk("rst_din",    64'(fifo_din),   64'(0));
    chk("rst_busy",   64'(busy),       64'(0));
    chk("rst_beats",  64'({beats1, beats0}), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    s0_valid  = 1'b0;
    s1_valid  = 1'b0;
    s0_data   = '0;
    s1_data   = '0;
    prog_full = 1'b0;
    fifo_full = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: lone s0 streams two full bursts separated by one idle cycle
    wr_seen  = 0;
    s0_valid = 1'b1;
    steps(34);
    chk("t1_writes", 64'(wr_seen), 64'(32));
    chk("t1_beats0", 64'(beats0),  64'(32));
    s0_valid = 1'b0;
    steps(2);

    // 2: both sources compete, ownership alternates starting with s0
    do_reset();
    grant_log.delete();
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    steps(51);
    chk("t2_bursts", 64'(grant_log.size()), 64'(3));
    chk("t2_own0",   64'(grant_log[0]), 64'(1));
    chk("t2_own1",   64'(grant_log[1]), 64'(2));
    chk("t2_own2",   64'(grant_log[2]), 64'(1));
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    steps(2);

    // 3: FIFO full for five cycles after beat 7; the burst still moves 16 beats
    do_reset();
    wr_seen  = 0;
    s0_valid = 1'b1;
    steps(8);
    fifo_full = 1'b1;
    steps(5);
    fifo_full = 1'b0;
    steps(9);
    chk("t3_writes", 64'(wr_seen), 64'(16));
    chk("t3_busy",   64'(busy),    64'(0));
    s0_valid = 1'b0;
    steps(2);

    // 4: prog_full rises at beat 3; burst completes, throttles, then hands over to s1
    do_reset();
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    steps(4);
    prog_full = 1'b1;
    steps(13);
    chk("t4_beats0", 64'(beats0), 64'(16));
    steps(4);
    chk("t4_throttle_busy", 64'(busy), 64'(1));
    prog_full = 1'b0;
    steps(2);
    chk("t4_next_owner", 64'(grant), 64'(2));
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    steps(3);

    // 5: s1 releases after 4 beats; s0 is preferred next
    do_reset();
    s1_valid = 1'b1;
    steps(5);
    s1_valid = 1'b0;
    steps(1);
    chk("t5_beats1", 64'(beats1), 64'(4));
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    steps(1);
    chk("t5_rr_s0", 64'(grant), 64'(1));
    steps(3);

    // 6: reset mid-burst, then s0 is granted first again
    do_reset();
    steps(6);
    do_reset();
    steps(1);
    chk("t6_restart", 64'(grant), 64'(1));
    steps(4);

    // Randomized traffic
    s0_valid  = 1'b0;
    s1_valid  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s0_valid  = ($urandom_range(0, 9) < 7);
      s1_valid  = ($urandom_range(0, 9) < 6);
      fifo_full = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) prog_full = ~prog_full;
      if ($urandom_range(0, 599) == 0) do_reset();
      steps(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
